// File: rtl/booth_wallace_mul_pipe.sv
// rtl/booth_wallace_mul_pipe.sv - 3-stage radix-4 Booth / Wallace-tree multiplier with valid/ready handshake
module booth_wallace_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int E   = WIDTH + 2;
    localparam int NPP = E / 2;
    localparam int P   = 2 * WIDTH;
    localparam int R   = NPP + 1;

    // Carry-save reduction of R rows down to two; row count per level is fixed by R,
    // so every guard below folds to a constant after unrolling.
    function automatic logic [1:0][P-1:0] wallace(input logic [R-1:0][P-1:0] rin);
        logic [R-1:0][P-1:0] cur;
        logic [R-1:0][P-1:0] nxt;
        logic [P-1:0]        a;
        logic [P-1:0]        b;
        logic [P-1:0]        c;
        int                  n;
        int                  m;
        cur = rin;
        n   = R;
        for (int lvl = 0; lvl < R; lvl++) begin
            if (n > 2) begin
                nxt = '0;
                m   = 0;
                for (int g = 0; g < R / 3; g++) begin
                    if (3 * g + 2 < n) begin
                        a          = cur[3*g];
                        b          = cur[3*g+1];
                        c          = cur[3*g+2];
                        nxt[m]     = a ^ b ^ c;
                        nxt[m+1]   = ((a & b) | (a & c) | (b & c)) << 1;
                        m          = m + 2;
                    end
                end
                for (int j = 0; j < R; j++) begin
                    if (j >= 3 * (n / 3) && j < n) begin
                        nxt[m] = cur[j];
                        m      = m + 1;
                    end
                end
                cur = nxt;
                n   = m;
            end
        end
        return {cur[1], cur[0]};
    endfunction

    logic                  adv;
    logic [E-1:0]          xe;
    logic [E-1:0]          ye;
    logic [E:0]            yb;
    logic [P-1:0]          xf;
    logic [P-1:0]          mag;
    logic [2:0]            trip;
    logic                  neg;
    logic [NPP-1:0][P-1:0] pp_d;
    logic [P-1:0]          corr_d;
    logic [1:0][P-1:0]     csa;

    logic                  s1_valid;
    logic [NPP-1:0][P-1:0] s1_pp;
    logic [P-1:0]          s1_corr;
    logic [TAG_W-1:0]      s1_tag;
    logic                  s2_valid;
    logic [P-1:0]          s2_sum;
    logic [P-1:0]          s2_carry;
    logic [TAG_W-1:0]      s2_tag;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Booth digit selection; negative digits are inverted here and the +1 lands in corr_d.
    always_comb begin
        xe     = in_signed ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
        ye     = in_signed ? {{2{in_y[WIDTH-1]}}, in_y} : {2'b00, in_y};
        yb     = {ye, 1'b0};
        xf     = {{(P-E){xe[E-1]}}, xe};
        pp_d   = '0;
        corr_d = '0;
        trip   = '0;
        mag    = '0;
        neg    = 1'b0;
        for (int i = 0; i < NPP; i++) begin
            trip = yb[2*i +: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = xf;
                3'b011, 3'b100:                 mag = xf << 1;
                default:                        mag = '0;
            endcase
            neg           = trip[2] & ~(trip[1] & trip[0]);
            pp_d[i]       = (neg ? ~mag : mag) << (2 * i);
            corr_d[2*i]   = neg;
        end
    end

    assign csa = wallace({s1_corr, s1_pp});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_pp     <= '0;
            s1_corr   <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_carry  <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_pp     <= pp_d;
            s1_corr   <= corr_d;
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_sum    <= csa[0];
            s2_carry  <= csa[1];
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_prod  <= s2_sum + s2_carry;
            out_tag   <= s2_tag;
        end
    end

endmodule
